// File: rtl/alu_16_seq.sv
// alu_16_seq: sequences 16- or 32-bit ops through an external 16-bit combinational ALU.
// Latency: response valid two edges after accept (narrow) or three edges (wide).
// Backpressure: the response holds in DONE until rsp_ready. No command is accepted until it drains.
module alu_16_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_mode,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_cin,
  input  logic        cmd_wide,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_mode,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [15:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_hi_q, a_hi_d;
  logic [15:0] b_hi_q, b_hi_d;
  logic        cin_q, cin_d;
  logic        wide_q, wide_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic        alu_mode_q, alu_mode_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic        alu_cin_q, alu_cin_d;
  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;

  // Ready is a decode of the state register. It is gated by reset_n so that it reads low
  // while reset is held and high right after release, which lets the first edge accept.
  assign cmd_ready  = (state_q == IDLE) && reset_n;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_mode   = alu_mode_q;
  assign alu_sel    = alu_sel_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = valid_q;
  assign rsp_result = result_q;
  assign rsp_cout   = cout_q;
  assign rsp_zero   = zero_q;

  // Next-state logic: latch the command, run the low pass, then the optional high pass, then hold the response.
  always_comb begin
    state_d    = state_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    cin_d      = cin_q;
    wide_d     = wide_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_mode_d = alu_mode_q;
    alu_sel_d  = alu_sel_q;
    alu_cin_d  = alu_cin_q;
    result_d   = result_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    valid_d    = valid_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_hi_d     = cmd_a[31:16];
          b_hi_d     = cmd_b[31:16];
          cin_d      = cmd_cin;
          wide_d     = cmd_wide;
          alu_a_d    = cmd_a[15:0];
          alu_b_d    = cmd_b[15:0];
          alu_mode_d = cmd_mode;
          alu_sel_d  = cmd_sel;
          alu_cin_d  = cmd_cin;
          state_d    = LO;
        end
      end
      LO: begin
        result_d = {16'h0000, alu_result};
        cout_d   = alu_cout;
        if (wide_q) begin
          alu_a_d   = a_hi_q;
          alu_b_d   = b_hi_q;
          // Arithmetic chains the low-pass carry. Logic ops reuse the command carry.
          alu_cin_d = alu_mode_q ? cin_q : alu_cout;
          state_d   = HI;
        end else begin
          zero_d  = (alu_result == 16'h0000);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      HI: begin
        result_d = {alu_result, result_q[15:0]};
        cout_d   = alu_cout;
        zero_d   = ({alu_result, result_q[15:0]} == 32'h0000_0000);
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_hi_q     <= 16'h0000;
      b_hi_q     <= 16'h0000;
      cin_q      <= 1'b1;
      wide_q     <= 1'b0;
      alu_a_q    <= 16'h0000;
      alu_b_q    <= 16'h0000;
      alu_mode_q <= 1'b0;
      alu_sel_q  <= 4'h0;
      alu_cin_q  <= 1'b1;
      result_q   <= 32'h0000_0000;
      cout_q     <= 1'b1;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_hi_q     <= a_hi_d;
      b_hi_q     <= b_hi_d;
      cin_q      <= cin_d;
      wide_q     <= wide_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      alu_sel_q  <= alu_sel_d;
      alu_cin_q  <= alu_cin_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_16_seq.sv
// Testbench for alu_16_seq: models the external 16-bit ALU and checks sequenced results
// against a single-shot 16/32-bit reference built from the ALU function table.
// Responses are sampled on the falling edge. Inputs are driven on the falling edge or just after the rising edge.
module tb_alu_16_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        cmd_cin = 1'b1;
  logic        cmd_wide = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic        alu_mode;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_16_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_sel(cmd_sel),
    .cmd_cin(cmd_cin), .cmd_wide(cmd_wide),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
  );

  // 181-style ALU function of width n (16 or 32). Returns {active-low carry-out, 32-bit result}.
  // Arithmetic is the sum of two select-gated terms plus carry. Carry-in is active low.
  function automatic logic [32:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic mode, input logic [3:0] s,
                                           input logic cin, input int n);
    logic [31:0] mask;
    logic [32:0] t1, t2, sum;
    logic [31:0] f;
    logic        carry;
    mask  = (n == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    t1    = {1'b0, (a | (b & {32{s[0]}}) | (~b & {32{s[1]}})) & mask};
    t2    = {1'b0, ((a & b & {32{s[3]}}) | (a & ~b & {32{s[2]}})) & mask};
    sum   = t1 + t2 + {32'h0, ~cin};
    carry = (n == 32) ? sum[32] : sum[16];
    if (mode) begin
      case (s)
        4'h0: f = ~a;
        4'h1: f = ~(a | b);
        4'h2: f = ~a & b;
        4'h3: f = '0;
        4'h4: f = ~(a & b);
        4'h5: f = ~b;
        4'h6: f = a ^ b;
        4'h7: f = a & ~b;
        4'h8: f = ~a | b;
        4'h9: f = ~(a ^ b);
        4'hA: f = b;
        4'hB: f = a & b;
        4'hC: f = '1;
        4'hD: f = a | ~b;
        4'hE: f = a | b;
        default: f = a;
      endcase
    end else begin
      f = sum[31:0];
    end
    return {~carry, f & mask};
  endfunction

  // External combinational ALU seen by the DUT.
  logic [32:0] alu_full;
  always_comb begin
    alu_full   = ref_calc({16'h0, alu_a}, {16'h0, alu_b}, alu_mode, alu_sel, alu_cin, 16);
    alu_result = alu_full[15:0];
    alu_cout   = alu_full[32];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One full command: accept, per-pass ALU drive checks, latency, result, stall, drain.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mode,
                       input logic [3:0] s, input logic cin, input logic wide, input int stall,
                       output logic [31:0] res, output logic cout_o, output logic zero_o,
                       output logic hicin);
    logic [32:0] exp_full, lo_full, hi_full;
    logic        exp_cout, exp_hicin;
    int          k;
    exp_full  = ref_calc(a, b, mode, s, cin, wide ? 32 : 16);
    lo_full   = ref_calc(a, b, mode, s, cin, 16);
    hi_full   = ref_calc(a >> 16, b >> 16, mode, s, cin, 16);
    exp_hicin = mode ? cin : lo_full[32];
    exp_cout  = (mode && wide) ? hi_full[32] : exp_full[32];
    hicin     = 1'b0;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_mode = mode; cmd_sel = s; cmd_cin = cin; cmd_wide = wide;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = $urandom; cmd_b = $urandom; cmd_mode = 1'($urandom);
    cmd_sel = 4'($urandom); cmd_cin = 1'($urandom); cmd_wide = 1'($urandom);
    k = 0;
    while (k < 8) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("lo_alu_a", alu_a, a[15:0]);
        chk("lo_alu_b", alu_b, b[15:0]);
        chk("lo_alu_mode_sel", {alu_mode, alu_sel}, {mode, s});
        chk("lo_alu_cin", alu_cin, cin);
        chk("cmd_ready_busy", cmd_ready, 0);
      end
      if (k == 2 && wide) begin
        hicin = alu_cin;
        chk("hi_alu_a", alu_a, a[31:16]);
        chk("hi_alu_b", alu_b, b[31:16]);
        chk("hi_alu_cin", alu_cin, exp_hicin);
      end
      if (rsp_valid) break;
    end
    chk("latency", k, wide ? 3 : 2);
    res = rsp_result; cout_o = rsp_cout; zero_o = rsp_zero;
    chk("rsp_result", rsp_result, exp_full[31:0]);
    chk("rsp_cout", rsp_cout, exp_cout);
    chk("rsp_zero", rsp_zero, exp_full[31:0] == 32'h0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_result", rsp_result, res);
      chk("stall_cout_zero", {rsp_cout, rsp_zero}, {cout_o, zero_o});
      chk("stall_alu_hold", alu_a, wide ? a[31:16] : a[15:0]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    logic [31:0] r;
    logic        c, z, hc;
    int          seen;

    // Reset state, checked before any clock edge and again after several edges in reset.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_cout_zero", {rsp_cout, rsp_zero}, 2'b10);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    chk("rst_alu_ctl", {alu_mode, alu_sel, alu_cin}, 6'b0_0000_1);
    repeat (3) @(negedge clk);
    chk("rst_hold_cmd_ready", cmd_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // Narrow logic XOR.
    do_op(32'h1234, 32'h4321, 1'b1, 4'b0110, 1'b1, 1'b0, 0, r, c, z, hc);
    chk("xor_result", r, 32'h0000_5115);
    chk("xor_zero", z, 0);

    // Wide add, with the carry chained into the high pass. The response is stalled for 5 cycles.
    do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 4'b1001, 1'b1, 1'b1, 5, r, c, z, hc);
    chk("add_hicin", hc, 0);
    chk("add_result", r, 32'h0001_0000);
    chk("add_cout_zero", {c, z}, 2'b10);

    // Wide subtract, with a borrow into the high pass.
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 4'b0110, 1'b0, 1'b1, 1, r, c, z, hc);
    chk("sub_hicin", hc, 1);
    chk("sub_result", r, 32'hFFFF_FFFF);
    chk("sub_cout", c, 1);

    // Zero flag on a narrow AND.
    do_op(32'h00FF, 32'hFF00, 1'b1, 4'b1011, 1'b1, 1'b0, 0, r, c, z, hc);
    chk("and_result", r, 32'h0);
    chk("and_zero", z, 1);

    // Narrow op with non-zero upper operand bits: the upper result bits must be zero.
    do_op(32'hABCD_8001, 32'h5555_8001, 1'b0, 4'b1001, 1'b1, 1'b0, 0, r, c, z, hc);
    chk("narrow_upper", r[31:16], 16'h0000);

    // Randomized ops against the reference.
    for (int i = 0; i < 30; i++) begin
      do_op($urandom, $urandom, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), r, c, z, hc);
    end

    // Reset asserted during the high pass of a wide add aborts it.
    @(negedge clk);
    cmd_a = 32'h0000_FFFF; cmd_b = 32'h0000_0001; cmd_mode = 1'b0;
    cmd_sel = 4'b1001; cmd_cin = 1'b1; cmd_wide = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_hi_cin", alu_cin, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_alu_cin", alu_cin, 1);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort_rel_ready", cmd_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", seen, 0);

    // A normal operation after the abort.
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 4'b1001, 1'b1, 1'b1, 0, r, c, z, hc);
    chk("post_abort_result", r, 32'h0);
    chk("post_abort_cout_zero", {c, z}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
